// File: rtl/demux_pkg.sv
// Shared constants and state encoding for the 1-to-16 demux frame collector.
package demux_pkg;

  localparam int N  = 16;
  localparam int SW = 4;

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_t;

endpackage

// File: rtl/dec4to16.sv
// Combinational 4-to-16 one-hot decoder; all-zero output when not enabled.
module dec4to16
  import demux_pkg::*;
(
  input  logic [SW-1:0] idx,
  input  logic          en,
  output logic [N-1:0]  onehot
);

  always_comb begin
    onehot = '0;
    if (en) onehot[idx] = 1'b1;
  end

endmodule

// File: rtl/demux116_collect.sv
// Registered 1-to-16 demultiplexer that gathers a full 16-bit word, then holds
// it under a valid/ack handshake while stalling the serial input.
module demux116_collect
  import demux_pkg::*;
#(
  parameter int N  = demux_pkg::N,
  parameter int SW = demux_pkg::SW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          y_in,
  input  logic [SW-1:0] s,
  input  logic          auto,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          clr,
  output logic [N-1:0]  o,
  output logic [N-1:0]  filled,
  output logic          out_valid,
  input  logic          out_ack
);

  state_t        state, state_nxt;
  logic [SW-1:0] cnt;
  logic [SW-1:0] idx;
  logic [N-1:0]  we;
  logic          wr;
  logic          full_nxt;
  logic          ack_take;

  assign wr       = in_valid & in_ready & ~clr;
  assign idx      = auto ? cnt : s;
  assign full_nxt = &(filled | we);
  assign ack_take = (state == HOLD) & out_ack & ~clr;

  dec4to16 u_dec (
    .idx    (idx),
    .en     (wr),
    .onehot (we)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= COLLECT;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      COLLECT: if (wr && full_nxt) state_nxt = HOLD;
      HOLD:    if (out_ack)        state_nxt = COLLECT;
      default:                     state_nxt = COLLECT;
    endcase
    if (clr) state_nxt = COLLECT;
  end

  always_comb begin
    in_ready  = (state == COLLECT);
    out_valid = (state == HOLD);
  end

  // Frame bookkeeping: abort or consumption restarts the position mask and counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filled <= '0;
      cnt    <= '0;
    end else if (clr || ack_take) begin
      filled <= '0;
      cnt    <= '0;
    end else begin
      filled <= filled | we;
      if (wr && auto) cnt <= cnt + SW'(1);
    end
  end

  // Data bits survive abort and consumption; only the addressed bit is replaced.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) o <= '0;
    else        o <= (o & ~we) | (we & {N{y_in}});
  end

endmodule

// File: tb/tb_demux116_collect.sv
// Directed bench for demux116_collect with hand-computed expected words.
module tb_demux116_collect;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        y_in = 1'b0;
  logic [3:0]  s = 4'd0;
  logic        auto = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        clr = 1'b0;
  logic [15:0] o;
  logic [15:0] filled;
  logic        out_valid;
  logic        out_ack = 1'b0;

  int checks = 0;
  int errors = 0;

  demux116_collect dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .y_in      (y_in),
    .s         (s),
    .auto      (auto),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .clr       (clr),
    .o         (o),
    .filled    (filled),
    .out_valid (out_valid),
    .out_ack   (out_ack)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic beat(input logic bit_v, input logic [3:0] sel, input logic a);
    y_in     = bit_v;
    s        = sel;
    auto     = a;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic ack_pulse();
    out_ack = 1'b1;
    @(posedge clk);
    #1;
    out_ack = 1'b0;
  endtask

  logic [15:0] pat;

  initial begin
    // Reset state before any edge
    #2;
    check_eq("rst_o", o, 16'h0000);
    check_eq("rst_ready", in_ready, 1'b1);
    check_eq("rst_valid", out_valid, 1'b0);
    #10 rst_n = 1'b1;

    // 1: asynchronous reset mid-frame
    for (int i = 0; i < 5; i++) beat(1'b1, 4'(i), 1'b0);
    check_eq("pre_rst_filled", filled, 16'h001F);
    check_eq("pre_rst_o", o, 16'h001F);
    #3 rst_n = 1'b0;
    #1;
    check_eq("arst_o", o, 16'h0000);
    check_eq("arst_filled", filled, 16'h0000);
    check_eq("arst_valid", out_valid, 1'b0);
    check_eq("arst_ready", in_ready, 1'b1);
    #2 rst_n = 1'b1;

    // 2: addressed mode, s = 15 down to 0
    pat = 16'hA5C3;
    for (int i = 15; i >= 0; i--) begin
      beat(pat[i], 4'(i), 1'b0);
      if (i == 1) check_eq("addr_valid_15", out_valid, 1'b0);
    end
    check_eq("addr_o", o, 16'hA5C3);
    check_eq("addr_valid", out_valid, 1'b1);
    check_eq("addr_ready", in_ready, 1'b0);
    beat(1'b0, 4'd0, 1'b0);
    beat(1'b0, 4'd0, 1'b0);
    check_eq("hold_o", o, 16'hA5C3);
    check_eq("hold_filled", filled, 16'hFFFF);
    ack_pulse();
    check_eq("addr_ack_valid", out_valid, 1'b0);
    check_eq("addr_ack_filled", filled, 16'h0000);

    // 3: auto mode, LSB first, random s
    pat = 16'h5352;
    for (int i = 0; i < 16; i++) beat(pat[i], 4'($urandom_range(0, 15)), 1'b1);
    check_eq("auto_o", o, 16'h5352);
    check_eq("auto_valid", out_valid, 1'b1);
    ack_pulse();
    beat(1'b1, 4'd7, 1'b1);
    check_eq("auto_cnt0_filled", filled, 16'h0001);
    check_eq("auto_cnt0_o", o, 16'h5353);
    clr = 1'b1;
    @(posedge clk);
    #1 clr = 1'b0;
    check_eq("clr_filled", filled, 16'h0000);

    // 4: overwrite of index 4, index 9 withheld
    beat(1'b1, 4'd4, 1'b0);
    beat(1'b0, 4'd4, 1'b0);
    for (int i = 0; i < 16; i++)
      if (i != 4 && i != 9) beat(1'b1, 4'(i), 1'b0);
    check_eq("ovr_valid", out_valid, 1'b0);
    check_eq("ovr_filled", filled, 16'hFDFF);
    check_eq("ovr_o4", o[4], 1'b0);
    beat(1'b1, 4'd9, 1'b0);
    check_eq("ovr_done_valid", out_valid, 1'b1);
    check_eq("ovr_done_o", o, 16'hFFEF);

    // 5: handshake stall then ack
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check_eq("hs_stall_valid", out_valid, 1'b1);
    end
    ack_pulse();
    check_eq("hs_valid", out_valid, 1'b0);
    check_eq("hs_ready", in_ready, 1'b1);
    check_eq("hs_filled", filled, 16'h0000);
    check_eq("hs_o", o, 16'hFFEF);
    out_ack = 1'b1;
    @(posedge clk);
    #1 out_ack = 1'b0;
    check_eq("ack_collect_ready", in_ready, 1'b1);

    // 6: clear after 7 auto writes, with a beat in the same cycle
    for (int i = 0; i < 7; i++) beat(1'b0, 4'd0, 1'b1);
    check_eq("clr_pre_filled", filled, 16'h007F);
    check_eq("clr_pre_o", o, 16'hFF80);
    clr = 1'b1; in_valid = 1'b1; s = 4'd2; y_in = 1'b1; auto = 1'b0;
    @(posedge clk);
    #1;
    clr = 1'b0; in_valid = 1'b0;
    check_eq("clr6_filled", filled, 16'h0000);
    check_eq("clr6_o", o, 16'hFF80);
    pat = 16'h1234;
    for (int i = 0; i < 16; i++) begin
      beat(pat[i], 4'd9, 1'b1);
      if (i == 0) check_eq("clr6_cnt0", filled, 16'h0001);
    end
    check_eq("clr6_frame_o", o, 16'h1234);
    check_eq("clr6_frame_valid", out_valid, 1'b1);
    ack_pulse();
    check_eq("final_valid", out_valid, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
